ppu_frame_timer: RTL and testbench
==================================

Name: ppu_frame_timer

Overview:
Dot/scanline sequencer for the PPU. Generates the 341x262 frame timebase and sets and clears the vblank flag, including the $2002-read race. Drives the active-low NMI line and issues the per-frame restart pulse that clears sprite-0-hit and overflow in the status latch. Sits between the CPU bus decode and the PPU render/status logic; every other PPU block keys off its counters.

Parameters:
DOTS_PER_LINE, 341, dots per scanline (dot counter range 0..DOTS_PER_LINE-1)
LINES_PER_FRAME, 262, scanlines per frame (scanline counter range 0..LINES_PER_FRAME-1)
VBLANK_LINE, 241, scanline on which vblank is set
PRERENDER_LINE, 261, pre-render scanline: vblank clear, frame restart, odd-frame skip

Ports:
clk  in  1  PPU dot clock; one dot per rising edge
rst  in  1  asynchronous, active-high reset
ppu_ctrl1  in  8  $2000 shadow; bit7 = NMI enable
ppu_ctrl2  in  8  $2001 shadow; bit3 = background enable, bit4 = sprite enable
cpu_addr  in  16  CPU bus address
cpu_rd  in  1  CPU read strobe, one clk per access
dot  out  9  current dot, 0..340
scanline  out  9  current scanline, 0..261
vblank_flag  out  1  status bit 7 source
nmi_n  out  1  active-low NMI to CPU
frame_restart  out  1  one-clk pulse at pre-render dot 1
odd_frame  out  1  frame parity
render_active  out  1  rendering enabled on a visible or pre-render line

Behaviour:
- Reset (async, rst=1): dot=0, scanline=0, vblank_flag=0, nmi_n=1, frame_restart=0, odd_frame=0.
- rendering_en = ppu_ctrl2[3] | ppu_ctrl2[4].
- status_rd = cpu_rd & (cpu_addr[15:13]==3'b001) & (cpu_addr[2:0]==3'd2). All $2002 mirrors in $2000-$3FFF decode.
- Counters advance every clk:
  - dot==DOTS_PER_LINE-1: dot wraps to 0 and scanline increments.
  - scanline==LINES_PER_FRAME-1 at that wrap: scanline goes to 0 and odd_frame toggles.
- Odd-frame skip: at scanline==PRERENDER_LINE, dot==DOTS_PER_LINE-2, with odd_frame=1 and rendering_en=1, the next state is dot 0 / scanline 0. Dot 340 is skipped and odd_frame toggles. rendering_en is sampled on that clk only.
- vblank set: on the edge where (scanline,dot)==(VBLANK_LINE,1), vblank_flag<=1. It is visible while the counters show dot 2.
- vblank clear:
  - Edge where (scanline,dot)==(PRERENDER_LINE,1).
  - Any edge with status_rd=1 while the flag is set; cleared on the following cycle.
- Race: status_rd on the same edge as the set condition leaves vblank_flag=0 for the whole frame and produces no NMI. A read at the edge after the set sees flag=1, clears it and lets NMI fire normally.
- Simultaneous clear and status_rd: the result is 0.
- nmi_n is registered: nmi_n <= ~(vblank_flag_next & ppu_ctrl1[7]).
  - Setting ppu_ctrl1[7] while vblank_flag=1 produces a new falling edge one clk later.
  - Clearing ppu_ctrl1[7] releases nmi_n one clk later.
- frame_restart: registered one-clk pulse, high in the cycle after the edge at (PRERENDER_LINE,1), i.e. coincident with vblank_flag falling.
- render_active = rendering_en & (scanline<240 | scanline==PRERENDER_LINE). Combinational from registered counters.
- Reset mid-frame: all state returns to reset values immediately. No pulse is emitted on reset release.
- Nothing else resets the counters; there is no CPU write path into them.

Test Plan:
- Release reset, rendering off, run 2 frames -> each frame exactly 89342 clks. vblank_flag rises when counters first read (241,2), i.e. 82183 clks after reset. It falls at (261,2), with frame_restart high that cycle.
- ppu_ctrl2=8'h18, run 4 frames -> frame lengths alternate 89342 (even), 89341 (odd). On odd frames, (261,339) is followed by (0,0). odd_frame toggles each frame.
- ppu_ctrl1=8'h80, no reads -> nmi_n low from (241,2) to (261,2). ppu_ctrl1=8'h00 -> nmi_n never low.
- status_rd (cpu_addr=16'h3FFA) on the set edge -> vblank_flag stays 0 and nmi_n stays 1 all frame. The same read one clk later -> flag seen 1, cleared next cycle, nmi_n pulses low one clk.
- During vblank with flag=1 and ctrl1 bit7=0, write ppu_ctrl1=8'h80 -> nmi_n falls next clk. A read of 16'h2002 -> flag and nmi_n release next clk.
- Assert rst at (100,150) for 3 clks -> all outputs at reset values asynchronously. After release, counting resumes from (0,0) and no frame_restart pulse occurs.

Source files
------------

// File: rtl/ppu_frame_timer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | ppu_frame_timer: PPU dot/scanline timebase, vblank flag, NMI, restart.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ppu_frame_timer #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ppu_ctrl1,
  input  logic [7:0]  ppu_ctrl2,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  output logic [8:0]  dot,
  output logic [8:0]  scanline,
  output logic        vblank_flag,
  output logic        nmi_n,
  output logic        frame_restart,
  output logic        odd_frame,
  output logic        render_active
);

  localparam logic [8:0] c_last_dot  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] c_skip_dot  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] c_last_line = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] c_vbl_line  = 9'(VBLANK_LINE);
  localparam logic [8:0] c_pre_line  = 9'(PRERENDER_LINE);
  localparam logic [8:0] c_vis_lines = 9'd240;

  logic [8:0] r_dot, r_line;
  logic       r_vbl, r_nmi_n, r_restart, r_odd;

  logic [8:0] w_dot_nxt, w_line_nxt;
  logic       w_odd_nxt, w_vbl_nxt;
  logic       w_render_en, w_status_rd, w_set, w_clr, w_skip;
  logic       w_unused;

  assign w_render_en = ppu_ctrl2[3] | ppu_ctrl2[4];
  // Any $2002 mirror inside $2000-$3FFF
  assign w_status_rd = cpu_rd && (cpu_addr[15:13] == 3'b001) && (cpu_addr[2:0] == 3'd2);
  assign w_set  = (r_line == c_vbl_line) && (r_dot == 9'd1);
  assign w_clr  = (r_line == c_pre_line) && (r_dot == 9'd1);
  assign w_skip = (r_line == c_pre_line) && (r_dot == c_skip_dot) && r_odd && w_render_en;

  assign w_unused = ^{cpu_addr[12:3], ppu_ctrl1[6:0], ppu_ctrl2[7:5], ppu_ctrl2[2:0]};

  always_comb begin
    w_dot_nxt  = r_dot + 9'd1;
    w_line_nxt = r_line;
    w_odd_nxt  = r_odd;
    if (w_skip) begin
      w_dot_nxt  = 9'd0;
      w_line_nxt = 9'd0;
      w_odd_nxt  = ~r_odd;
    end else if (r_dot == c_last_dot) begin
      w_dot_nxt = 9'd0;
      if (r_line == c_last_line) begin
        w_line_nxt = 9'd0;
        w_odd_nxt  = ~r_odd;
      end else begin
        w_line_nxt = r_line + 9'd1;
      end
    end
  end

  // A read on the set edge wins, which suppresses the flag and NMI for the frame
  always_comb begin
    w_vbl_nxt = r_vbl;
    if (w_clr || w_status_rd) begin
      w_vbl_nxt = 1'b0;
    end else if (w_set) begin
      w_vbl_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dot     <= 9'd0;
      r_line    <= 9'd0;
      r_vbl     <= 1'b0;
      r_nmi_n   <= 1'b1;
      r_restart <= 1'b0;
      r_odd     <= 1'b0;
    end else begin
      r_dot     <= w_dot_nxt;
      r_line    <= w_line_nxt;
      r_odd     <= w_odd_nxt;
      r_vbl     <= w_vbl_nxt;
      r_nmi_n   <= ~(w_vbl_nxt & ppu_ctrl1[7]);
      r_restart <= w_clr;
    end
  end

  assign dot           = r_dot;
  assign scanline      = r_line;
  assign vblank_flag   = r_vbl;
  assign nmi_n         = r_nmi_n;
  assign frame_restart = r_restart;
  assign odd_frame     = r_odd;
  assign render_active = w_render_en && ((r_line < c_vis_lines) || (r_line == c_pre_line));

endmodule
`default_nettype wire

// File: tb/tb_ppu_frame_timer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_ppu_frame_timer: full-size timing run plus small-frame model checks.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_ppu_frame_timer;

  localparam int SD = 20;
  localparam int SL = 16;
  localparam int SV = 12;
  localparam int SP = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small-frame instance
  logic        s_rst;
  logic [7:0]  s_c1, s_c2;
  logic [15:0] s_addr;
  logic        s_rd;
  logic [8:0]  s_dot, s_line;
  logic        s_vbl, s_nmi, s_rs, s_odd, s_ra;

  // Full-size instance
  logic        f_rst;
  logic [7:0]  f_c1, f_c2;
  logic [15:0] f_addr;
  logic        f_rd;
  logic [8:0]  f_dot, f_line;
  logic        f_vbl, f_nmi, f_rs, f_odd, f_ra;

  ppu_frame_timer #(
    .DOTS_PER_LINE(SD), .LINES_PER_FRAME(SL), .VBLANK_LINE(SV), .PRERENDER_LINE(SP)
  ) u_small (
    .clk(clk), .rst(s_rst), .ppu_ctrl1(s_c1), .ppu_ctrl2(s_c2), .cpu_addr(s_addr),
    .cpu_rd(s_rd), .dot(s_dot), .scanline(s_line), .vblank_flag(s_vbl), .nmi_n(s_nmi),
    .frame_restart(s_rs), .odd_frame(s_odd), .render_active(s_ra)
  );

  ppu_frame_timer u_full (
    .clk(clk), .rst(f_rst), .ppu_ctrl1(f_c1), .ppu_ctrl2(f_c2), .cpu_addr(f_addr),
    .cpu_rd(f_rd), .dot(f_dot), .scanline(f_line), .vblank_flag(f_vbl), .nmi_n(f_nmi),
    .frame_restart(f_rs), .odd_frame(f_odd), .render_active(f_ra)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: linear position within the frame
  int m_pos, m_frame;
  bit m_odd, m_vbl, m_nmi_n, m_rs;

  task automatic m_reset();
    m_pos = 0; m_frame = 0; m_odd = 0; m_vbl = 0; m_nmi_n = 1; m_rs = 0;
  endtask

  task automatic m_step();
    bit rend, srd;
    int set_p, clr_p, skip_p;
    rend   = s_c2[3] | s_c2[4];
    srd    = s_rd && (s_addr[15:13] == 3'b001) && (s_addr[2:0] == 3'd2);
    set_p  = SV * SD + 1;
    clr_p  = SP * SD + 1;
    skip_p = SP * SD + SD - 2;
    if (m_pos == clr_p || srd) m_vbl = 0;
    else if (m_pos == set_p)   m_vbl = 1;
    m_nmi_n = !(m_vbl && s_c1[7]);
    m_rs    = (m_pos == clr_p);
    if ((m_pos == skip_p && m_odd && rend) || m_pos == SD * SL - 1) begin
      m_pos = 0; m_odd = !m_odd; m_frame++;
    end else begin
      m_pos++;
    end
  endtask

  task automatic cmp_all(input string tag);
    int ln;
    ln = m_pos / SD;
    check({tag, " dot"},      s_dot,  m_pos % SD);
    check({tag, " scanline"}, s_line, ln);
    check({tag, " vblank"},   s_vbl,  m_vbl);
    check({tag, " nmi_n"},    s_nmi,  m_nmi_n);
    check({tag, " restart"},  s_rs,   m_rs);
    check({tag, " odd"},      s_odd,  m_odd);
    check({tag, " render"},   s_ra,   (s_c2[3] | s_c2[4]) && (ln < 240 || ln == SP));
  endtask

  task automatic s_tick(input string tag);
    m_step();
    @(negedge clk);
    cmp_all(tag);
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  c1, c2;
    logic [15:0] addr;
    logic        rd;
    int          dot, line;
    logic        vbl, nmi_n, rs, odd, ra;
  } vec_t;

  task automatic run_small();
    vec_t tbl[7];
    bit   found;
    tbl[0] = '{1'b1, 8'h00, 8'h00, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 8'h08, 16'h0000, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 8'h10, 16'h2002, 1'b1, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h80, 8'h00, 16'h3FFA, 1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h00, 8'h18, 16'h0000, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 8'h18, 16'h0000, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      s_rst = tbl[i].rst; s_c1 = tbl[i].c1; s_c2 = tbl[i].c2;
      s_addr = tbl[i].addr; s_rd = tbl[i].rd;
      @(negedge clk);
      check($sformatf("tbl%0d dot", i),      s_dot,  tbl[i].dot);
      check($sformatf("tbl%0d scanline", i), s_line, tbl[i].line);
      check($sformatf("tbl%0d vblank", i),   s_vbl,  tbl[i].vbl);
      check($sformatf("tbl%0d nmi_n", i),    s_nmi,  tbl[i].nmi_n);
      check($sformatf("tbl%0d restart", i),  s_rs,   tbl[i].rs);
      check($sformatf("tbl%0d odd", i),      s_odd,  tbl[i].odd);
      check($sformatf("tbl%0d render", i),   s_ra,   tbl[i].ra);
    end

    s_rst = 1'b1; s_rd = 1'b0;
    @(negedge clk);
    s_rst = 1'b0;
    m_reset();

    // Directed frames 0-3 (race, late read, NMI enable mid-vblank), then random
    for (int n = 0; n < 6000 && m_frame < 13; n++) begin
      s_rd = 1'b0;
      s_addr = 16'h0000;
      if (m_frame < 4) begin
        s_c2 = 8'h18;
        s_c1 = 8'h80;
        if (m_frame == 1 && m_pos == SV * SD + 1) begin s_rd = 1'b1; s_addr = 16'h3FFA; end
        if (m_frame == 2 && m_pos == SV * SD + 2) begin s_rd = 1'b1; s_addr = 16'h3FFA; end
        if (m_frame == 3) begin
          s_c1 = (m_pos >= SV * SD + 5) ? 8'h80 : 8'h00;
          if (m_pos == SV * SD + 8) begin s_rd = 1'b1; s_addr = 16'h2002; end
        end
      end else begin
        if ($urandom % 16 == 0) s_c1 = 8'($urandom);
        if ($urandom % 64 == 0) s_c2 = 8'($urandom) & 8'h18;
        s_rd = ($urandom % 6 == 0);
        case ($urandom % 3)
          0:       s_addr = 16'h2002 | (16'($urandom) & 16'h1FF8);
          1:       s_addr = 16'($urandom);
          default: s_addr = 16'h2002 ^ (16'h1 << ($urandom % 16));
        endcase
      end
      s_tick($sformatf("f%0d", m_frame));
    end
    check("small frames reached", m_frame, 13);

    s_c2 = 8'h18; s_c1 = 8'h80; s_rd = 1'b0;
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (m_pos == 8 * SD + 15) found = 1;
      else s_tick("seek");
    end
    check("midreset reached", found, 1);

    s_rst = 1'b1;
    #1;
    m_reset();
    cmp_all("async rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_all("hold rst");
    end
    s_rst = 1'b0;
    for (int i = 0; i < 30; i++) s_tick("post rst");
  endtask

  task automatic run_full();
    int rise, fall, wrap, restarts, nmi_lows;
    rise = -1; fall = -1; wrap = -1; restarts = 0; nmi_lows = 0;
    @(negedge clk);
    check("full rst dot", f_dot, 0);
    check("full rst vblank", f_vbl, 0);
    check("full rst nmi_n", f_nmi, 1);
    f_rst = 1'b0;
    for (int n = 1; n <= 89400 && wrap < 0; n++) begin
      @(negedge clk);
      if (f_rs) restarts++;
      if (!f_nmi) nmi_lows++;
      if (rise < 0 && f_vbl) begin
        rise = n;
        check("full set dot", f_dot, 2);
        check("full set line", f_line, 241);
        check("full set nmi_n", f_nmi, 0);
      end
      if (rise >= 0 && fall < 0 && !f_vbl) begin
        fall = n;
        check("full clr dot", f_dot, 2);
        check("full clr line", f_line, 261);
        check("full clr restart", f_rs, 1);
        check("full clr nmi_n", f_nmi, 1);
      end
      if (f_dot == 9'd0 && f_line == 9'd0) begin
        wrap = n;
        check("full wrap odd", f_odd, 1);
      end
    end
    check("full vblank rise clk", rise, 82183);
    check("full vblank fall clk", fall, 89003);
    check("full frame length", wrap, 89342);
    check("full restart pulses", restarts, 1);
    check("full nmi low clks", nmi_lows, 6820);
  endtask

  initial begin
    s_rst = 1'b1; s_c1 = 8'h00; s_c2 = 8'h00; s_addr = 16'h0000; s_rd = 1'b0;
    f_rst = 1'b1; f_c1 = 8'h80; f_c2 = 8'h00; f_addr = 16'h0000; f_rd = 1'b0;
    m_reset();
    fork
      run_small();
      run_full();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
